// File: rtl/spm_pkg.sv
// rtl/spm_pkg.sv - shared state encoding and RUN-length helper for the spm sequencer
package spm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Product bits trail the multiplier bits by the array latency.
  function automatic int run_len(input int n, input int arr_lat);
    return 2 * n + arr_lat;
  endfunction

endpackage

// File: rtl/spm_sipo.sv
// rtl/spm_sipo.sv - serial-in parallel-out result register, fills from the MSB side
module spm_sipo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {din, q[W-1:1]};
    end
  end

endmodule

// File: rtl/spm_seq_ctrl.sv
// rtl/spm_seq_ctrl.sv - operand sequencer and result collector for the spm multiplier array
// Build option: define SPM_SEQ_CTRL_SIGNED_EN for two's-complement operands.
module spm_seq_ctrl
  import spm_pkg::*;
#(
  parameter int N       = 8,
  parameter int ARR_LAT = 1,
  parameter int CW      = $clog2(2 * N + ARR_LAT + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic [N-1:0]   mc,
  input  logic [N-1:0]   mp,
  output logic [N-1:0]   x_out,
  output logic           y_out,
  output logic           arr_clr,
  input  logic           p_in,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*N-1:0] prod
);

  localparam int            RUN_LEN = run_len(N, ARR_LAT);
  localparam logic [CW-1:0] LAST_K  = CW'(RUN_LEN - 1);
  localparam logic [CW-1:0] FIRST_P = CW'(ARR_LAT);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0]  mp_sr;
  logic          fill;
  logic          accept;
  logic          shift_en;

  assign accept   = start_valid && (state == IDLE);
  assign shift_en = (state == RUN) && (cnt >= FIRST_P);

`ifdef SPM_SEQ_CTRL_SIGNED_EN
  // Arithmetic shift keeps replaying the sign bit once the operand is exhausted.
  assign fill = mp_sr[N-1];
`else
  assign fill = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_valid) state_nxt = CLR;
      CLR:     state_nxt = RUN;
      RUN:     if (cnt == LAST_K) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_ready = (state == IDLE);
    arr_clr     = (state == CLR);
    res_valid   = (state == DONE);
    y_out       = (state == RUN) ? mp_sr[0] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      mp_sr <= '0;
      x_out <= '0;
    end else begin
      if (state == CLR) begin
        cnt <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + CW'(1);
      end
      // x_out is only replaced by the next accepted operand pair.
      if (accept) begin
        x_out <= mc;
        mp_sr <= mp;
      end else if (state == RUN) begin
        mp_sr <= {fill, mp_sr[N-1:1]};
      end
    end
  end

  spm_sipo #(
    .W(2 * N)
  ) u_sipo (
    .clk      (clk),
    .rst      (rst),
    .clr      (arr_clr),
    .shift_en (shift_en),
    .din      (p_in),
    .q        (prod)
  );

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// tb/tb_spm_seq_ctrl.sv - directed bench for spm_seq_ctrl with behavioural array models
module tb_spm_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_valid = 1'b0, start_valid3 = 1'b0;
  logic        res_ready = 1'b0, res_ready3 = 1'b0;
  logic [7:0]  mc = 8'd0, mp = 8'd0;

  logic        start_ready1, y_out1, arr_clr1, res_valid1, p_in1;
  logic [7:0]  x_out1;
  logic [15:0] prod1;
  logic        start_ready3, y_out3, arr_clr3, res_valid3, p_in3;
  logic [7:0]  x_out3;
  logic [15:0] prod3;

  int vec  = 0;
  int errs = 0;

`ifdef SPM_SEQ_CTRL_SIGNED_EN
  localparam logic [15:0] E_MAX = 16'h0001;
  localparam logic [15:0] E_S   = 16'hFFF1;
  localparam logic [7:0]  E_YHI = 8'hFF;
`else
  localparam logic [15:0] E_MAX = 16'hFE01;
  localparam logic [15:0] E_S   = 16'h04F1;
  localparam logic [7:0]  E_YHI = 8'h00;
`endif

  always #5 clk = ~clk;

  spm_seq_ctrl #(.N(8), .ARR_LAT(1)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready1),
    .mc(mc), .mp(mp), .x_out(x_out1), .y_out(y_out1), .arr_clr(arr_clr1),
    .p_in(p_in1), .res_valid(res_valid1), .res_ready(res_ready), .prod(prod1)
  );

  spm_seq_ctrl #(.N(8), .ARR_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start_valid(start_valid3), .start_ready(start_ready3),
    .mc(mc), .mp(mp), .x_out(x_out3), .y_out(y_out3), .arr_clr(arr_clr3),
    .p_in(p_in3), .res_valid(res_valid3), .res_ready(res_ready3), .prod(prod3)
  );

  // Behavioural serial-parallel array: partial sum plus selected x, emit LSB, shift.
  function automatic logic signed [17:0] ext(input logic [7:0] x);
`ifdef SPM_SEQ_CTRL_SIGNED_EN
    return {{10{x[7]}}, x};
`else
    return {10'd0, x};
`endif
  endfunction

  logic signed [17:0] r1 = '0, r3 = '0, t1, t3;
  logic               d1 = 1'b0;
  logic [2:0]         d3 = 3'b000;

  assign t1    = r1 + (y_out1 ? ext(x_out1) : 18'sd0);
  assign t3    = r3 + (y_out3 ? ext(x_out3) : 18'sd0);
  assign p_in1 = d1;
  assign p_in3 = d3[2];

  always @(posedge clk) begin
    if (arr_clr1) r1 <= '0;
    else begin
      r1 <= t1 >>> 1;
      d1 <= t1[0];
    end
    if (arr_clr3) r3 <= '0;
    else begin
      r3 <= t3 >>> 1;
      d3 <= {d3[1:0], t3[0]};
    end
  end

  // Drives one operand pair (called at a negedge) and observes the run until res_valid.
  task automatic do_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] p, output int lat, output int nclr,
                       output logic [31:0] ys);
    int n;
    ys = '0; nclr = 0; lat = -1; n = 0;
    while (!(sel ? start_ready3 : start_ready1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    mc = a; mp = b;
    if (sel) start_valid3 = 1'b1; else start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0; start_valid3 = 1'b0;
    for (int i = 1; i < 100; i++) begin
      if (sel ? arr_clr3 : arr_clr1) nclr++;
      if (i >= 2 && i < 34) ys[i-2] = sel ? y_out3 : y_out1;
      if (sel ? res_valid3 : res_valid1) begin
        lat = i - 1;
        break;
      end
      @(negedge clk);
    end
    p = sel ? prod3 : prod1;
  endtask

  task automatic take_result(input bit sel);
    start_valid = 1'b0;
    if (sel) res_ready3 = 1'b1; else res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0; res_ready3 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vec++; if (start_ready1 !== 1'b1) begin errs++; $display("FAIL rst_start_ready: got %b want 1", start_ready1); end
    vec++; if (res_valid1 !== 1'b0) begin errs++; $display("FAIL rst_res_valid: got %b want 0", res_valid1); end
    vec++; if (arr_clr1 !== 1'b0) begin errs++; $display("FAIL rst_arr_clr: got %b want 0", arr_clr1); end
    vec++; if (y_out1 !== 1'b0) begin errs++; $display("FAIL rst_y_out: got %b want 0", y_out1); end
    vec++; if (x_out1 !== 8'h00) begin errs++; $display("FAIL rst_x_out: got %h want 00", x_out1); end
    vec++; if (prod1 !== 16'h0000) begin errs++; $display("FAIL rst_prod: got %h want 0000", prod1); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] p; int lat, nclr; logic [31:0] ys;
    do_op(1'b0, 8'd3, 8'd5, p, lat, nclr, ys);
    vec++; if (p !== 16'h000F) begin errs++; $display("FAIL basic_prod: got %h want 000f", p); end
    vec++; if (lat !== 18) begin errs++; $display("FAIL basic_latency: got %0d want 18", lat); end
    vec++; if (nclr !== 1) begin errs++; $display("FAIL basic_arr_clr_cycles: got %0d want 1", nclr); end
    vec++; if (ys[15:0] !== 16'h0005) begin errs++; $display("FAIL basic_y_seq: got %h want 0005", ys[15:0]); end
    vec++; if (x_out1 !== 8'd3) begin errs++; $display("FAIL basic_x_hold: got %h want 03", x_out1); end
    take_result(1'b0);
    vec++; if (res_valid1 !== 1'b0) begin errs++; $display("FAIL basic_valid_drop: got %b want 0", res_valid1); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] p; int lat, nclr; logic [31:0] ys;
    do_op(1'b0, 8'd255, 8'd255, p, lat, nclr, ys);
    vec++; if (p !== E_MAX) begin errs++; $display("FAIL max_prod: got %h want %h", p, E_MAX); end
    take_result(1'b0);
    vec++; if (start_ready1 !== 1'b1) begin errs++; $display("FAIL b2b_ready_after_hs: got %b want 1", start_ready1); end
    do_op(1'b0, 8'd2, 8'd7, p, lat, nclr, ys);
    vec++; if (p !== 16'h000E) begin errs++; $display("FAIL b2b_prod: got %h want 000e", p); end
    vec++; if (lat !== 18) begin errs++; $display("FAIL b2b_latency: got %0d want 18", lat); end
    take_result(1'b0);
  endtask

  task automatic test_signed();
    logic [15:0] p; int lat, nclr; logic [31:0] ys;
    do_op(1'b0, 8'hFD, 8'h05, p, lat, nclr, ys);
    vec++; if (p !== E_S) begin errs++; $display("FAIL sgn_neg_mc_prod: got %h want %h", p, E_S); end
    take_result(1'b0);
    do_op(1'b0, 8'h05, 8'hFD, p, lat, nclr, ys);
    vec++; if (p !== E_S) begin errs++; $display("FAIL sgn_neg_mp_prod: got %h want %h", p, E_S); end
    vec++; if (ys[7:0] !== 8'hFD) begin errs++; $display("FAIL sgn_y_low: got %h want fd", ys[7:0]); end
    vec++; if (ys[15:8] !== E_YHI) begin errs++; $display("FAIL sgn_y_ext: got %h want %h", ys[15:8], E_YHI); end
    take_result(1'b0);
  endtask

  task automatic test_backpressure();
    logic [15:0] p; int lat, nclr; logic [31:0] ys;
    do_op(1'b0, 8'd4, 8'd9, p, lat, nclr, ys);
    vec++; if (p !== 16'h0024) begin errs++; $display("FAIL bp_prod: got %h want 0024", p); end
    for (int c = 0; c < 10; c++) begin
      start_valid = 1'b1; mc = 8'hAA; mp = 8'h55;
      @(negedge clk);
      vec++; if (res_valid1 !== 1'b1) begin errs++; $display("FAIL bp_valid c%0d: got %b want 1", c, res_valid1); end
      vec++; if (prod1 !== 16'h0024) begin errs++; $display("FAIL bp_prod_stable c%0d: got %h want 0024", c, prod1); end
      vec++; if (start_ready1 !== 1'b0) begin errs++; $display("FAIL bp_start_ready c%0d: got %b want 0", c, start_ready1); end
      vec++; if (x_out1 !== 8'd4) begin errs++; $display("FAIL bp_x_out c%0d: got %h want 04", c, x_out1); end
    end
    start_valid = 1'b0;
    take_result(1'b0);
    vec++; if (start_ready1 !== 1'b1) begin errs++; $display("FAIL bp_idle_after: got %b want 1", start_ready1); end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] p; int lat, nclr; logic [31:0] ys;
    mc = 8'hFF; mp = 8'hFF; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (6) @(negedge clk);
    vec++; if (y_out1 !== 1'b1) begin errs++; $display("FAIL midrun_y_before: got %b want 1", y_out1); end
    rst = 1'b0;
    #1;
    vec++; if (start_ready1 !== 1'b1) begin errs++; $display("FAIL midrun_start_ready: got %b want 1", start_ready1); end
    vec++; if (res_valid1 !== 1'b0) begin errs++; $display("FAIL midrun_res_valid: got %b want 0", res_valid1); end
    vec++; if (arr_clr1 !== 1'b0) begin errs++; $display("FAIL midrun_arr_clr: got %b want 0", arr_clr1); end
    vec++; if (y_out1 !== 1'b0) begin errs++; $display("FAIL midrun_y_out: got %b want 0", y_out1); end
    vec++; if (x_out1 !== 8'h00) begin errs++; $display("FAIL midrun_x_out: got %h want 00", x_out1); end
    vec++; if (prod1 !== 16'h0000) begin errs++; $display("FAIL midrun_prod: got %h want 0000", prod1); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_op(1'b0, 8'd6, 8'd7, p, lat, nclr, ys);
    vec++; if (p !== 16'h002A) begin errs++; $display("FAIL midrun_after_prod: got %h want 002a", p); end
    take_result(1'b0);
  endtask

  task automatic test_arr_lat3();
    logic [15:0] p; int lat, nclr; logic [31:0] ys;
    do_op(1'b1, 8'd10, 8'd12, p, lat, nclr, ys);
    vec++; if (p !== 16'h0078) begin errs++; $display("FAIL lat3_prod: got %h want 0078", p); end
    vec++; if (lat !== 20) begin errs++; $display("FAIL lat3_latency: got %0d want 20", lat); end
    vec++; if (nclr !== 1) begin errs++; $display("FAIL lat3_arr_clr_cycles: got %0d want 1", nclr); end
    take_result(1'b1);
    vec++; if (res_valid3 !== 1'b0) begin errs++; $display("FAIL lat3_valid_drop: got %b want 0", res_valid3); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_signed();
    test_backpressure();
    test_reset_mid_run();
    test_arr_lat3();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/spm_seq_ctrl.md
Name: spm_seq_ctrl

Overview:
- Sequencing front/back end for the spm serial-parallel multiplier array.
- Sits directly upstream of the CSA chain. Accepts parallel operands on a valid/ready handshake and holds the multiplicand on the array's parallel x bus.
- Serialises the multiplier LSB-first onto the array's serial y input.
- Collects the serial product bit stream back into a parallel 2N-bit result with its own valid/ready handshake.

Parameters:
- N, 8, operand width in bits; must be ≥2. The product is 2N bits wide.
- ARR_LAT, 1, cycles from a y_out bit being driven to the matching product bit appearing on p_in; must be ≥1.
- CW, $clog2(2*N+ARR_LAT+1), width of the internal cycle counter.

Ports:
- clk, input, 1, single clock; rising edge.
- rst, input, 1, asynchronous active-low reset.
- start_valid, input, 1, operand pair offered.
- start_ready, output, 1, controller can accept operands.
- mc, input, N, multiplicand (x).
- mp, input, N, multiplier (y).
- x_out, output, N, parallel multiplicand to the array.
- y_out, output, 1, serial multiplier bit to the array.
- arr_clr, output, 1, one-cycle synchronous clear of the array's sum/carry registers.
- p_in, input, 1, serial product bit from the array.
- res_valid, output, 1, product available.
- res_ready, input, 1, consumer takes the product.
- prod, output, 2N, product, bit 0 = LSB.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, start_ready=1, res_valid=0, arr_clr=0, y_out=0.
  - x_out=0, prod=0, counter=0, internal shift registers=0.
- IDLE:
  - start_ready=1.
  - On start_valid&start_ready: latch mc into x_out and mp into the multiplier shift register; go to CLR.
- CLR (1 cycle):
  - start_ready=0, arr_clr=1, counter cleared; go to RUN.
- RUN (2N+ARR_LAT cycles, counter k=0..2N+ARR_LAT-1):
  - y_out = LSB of the multiplier shift register. The register shifts right each cycle; the fill bit is the extension bit (see Optional Feature).
  - For k ≥ ARR_LAT: p_in is shifted into the result register from the MSB side (right shift).
  - After the last cycle, bit 0 holds product bit 0. Go to DONE.
- DONE:
  - res_valid=1 and prod stable until the res_valid&res_ready handshake; then go to IDLE.
  - start_ready=0 in DONE. A start offered while DONE waits: there is no overlap, and a result is never overwritten.
- Latency: accept at edge 0 → res_valid high after edge 2N+ARR_LAT+1.
  - Example: N=8, ARR_LAT=1 → after edge 18.
- x_out holds its value from accept until the next accept; it is not cleared in DONE.
- arr_clr is asserted only in CLR.
- Product is taken modulo 2^(2N); no overflow flag.
- res_ready while not res_valid is ignored. start_valid outside IDLE is ignored; mc/mp are not sampled.
- Reset mid-RUN or mid-DONE: immediate return to reset values. A partial result is never presented.

Optional Feature:
- Macro: SPM_SEQ_CTRL_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - The multiplier shift register fills with mp[N-1] (sign extension) for cycles N..2N-1 and beyond.
  - mc is passed to the array unchanged; the array handles its sign.
  - prod is the signed 2N-bit product.
- Undefined:
  - Fill bit is 0 (zero extension).
  - prod is the unsigned product.

Decomposition:
- Package spm_pkg holds:
  - state typedef: enum {IDLE, CLR, RUN, DONE} encoded in 2 bits;
  - localparam helpers for the RUN length (2*N+ARR_LAT).
- One sub-module: spm_sipo. Serial-in parallel-out 2N-bit result register with shift-enable and hold. Reused later by the output-side partitions.
- Multiplier serialiser stays inline; it is too small to split out.

Test Plan:
- Unsigned, N=8, ARR_LAT=1, behavioural array model:
  - mc=3, mp=5 → prod=16'h000F.
  - res_valid after edge 18.
  - arr_clr high exactly 1 cycle.
  - y_out sequence 1,0,1,0,0…
- Unsigned max: mc=255, mp=255 → prod=16'hFE01. Back-to-back: a second start (mc=2, mp=7) is accepted the cycle after the res handshake → prod=16'h000E.
- SPM_SEQ_CTRL_SIGNED_EN: mc=8'hFD (−3), mp=8'h05 → prod=16'hFFF1. mc=8'h05, mp=8'hFD → 16'hFFF1, with y_out=1 for cycles 8..15.
- Backpressure: res_ready held 0 for 10 cycles after res_valid.
  - prod and res_valid stay stable.
  - start_valid=1 during this time is not accepted (start_ready=0).
- Reset mid-RUN: rst=0 at RUN k=5 → all outputs at reset values on the same cycle. After release, a new mc=6, mp=7 → prod=16'h002A.
- ARR_LAT=3 build: mc=10, mp=12 → prod=16'h0078; res_valid after edge 20.
